// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// PC mux selects, opcode constants and datapath widths.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 9;
    localparam int OP_W    = 5;

    localparam logic [OP_W-1:0] OP_NOP    = 5'b00000;
    localparam logic [OP_W-1:0] OP_BRANCH = 5'b10001;
    localparam logic [OP_W-1:0] OP_JUMP   = 5'b10010;
    localparam logic [OP_W-1:0] OP_HALT   = 5'b11010;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

    // The opcode field sits in the top five bits of every instruction word.
    function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, hold, modulo-2^16 increment
// and redirect-target load, selected by the fetch FSM.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'd1
) (
    input  logic            clk,
    input  logic            reset,
    input  pc_sel_e         pc_sel,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            unique case (pc_sel)
                PC_INC:  pc <= pc + 1'b1;
                PC_LOAD: pc <= load_pc;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage with IF/ID register, stall/redirect handling and a
// halt FSM. Define FETCH_PERF_CNT_EN to add the fetch/stall performance counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'd1,
    parameter logic [OP_W-1:0] HALT_OP  = OP_HALT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt,
`endif
    output logic               halted
);

    fetch_state_e state, state_nxt;
    pc_sel_e      pc_sel;
    logic         latch_en;
    logic         clear_valid;
    logic         is_halt;

    assign is_halt = (opcode_of(instr_in) == HALT_OP);

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .pc_sel  (pc_sel),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (!redirect && !stall && is_halt) state_nxt = HALT_PEND;
            end
            HALT_PEND: begin
                if (redirect)    state_nxt = RUN;
                else if (!stall) state_nxt = HALTED;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Redirect wins over stall and halt in both live states; HALTED ignores all.
    always_comb begin
        pc_sel      = PC_HOLD;
        latch_en    = 1'b0;
        clear_valid = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    pc_sel      = PC_LOAD;
                    clear_valid = 1'b1;
                end else if (!stall) begin
                    latch_en = 1'b1;
                    pc_sel   = is_halt ? PC_HOLD : PC_INC;
                end
            end
            HALT_PEND: begin
                if (redirect) begin
                    pc_sel      = PC_LOAD;
                    clear_valid = 1'b1;
                end else if (!stall) begin
                    clear_valid = 1'b1;
                end
            end
            default: begin
                pc_sel = PC_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (latch_en) begin
            ifid_instr <= instr_in;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
        end else if (clear_valid) begin
            ifid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) halted <= 1'b0;
        else       halted <= (state_nxt == HALTED);
    end

`ifdef FETCH_PERF_CNT_EN
    // Both counters saturate and stop counting once fetch has halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (latch_en && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 1'b1;
            if (state != HALTED && stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a behavioural fetch model checked
// every cycle, plus directed literal expectations for the key scenarios.
module tb_fetch_controller;

    localparam logic [4:0] TB_HALT_OP = 5'b11010;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [8:0]  instr_in;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [8:0]  ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic        cmp_en    = 1'b0;
    logic        halt_on   = 1'b0;
    logic [15:0] halt_addr = 16'h0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr_in    (instr_in),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_valid  (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .halted      (halted)
    );

    // ROM contents: ordinary words never carry the halt opcode (top bit 0);
    // one selectable address holds the halt instruction.
    function automatic logic [8:0] rom_word(input logic [15:0] a);
        if (halt_on && a == halt_addr) return {TB_HALT_OP, 4'h0};
        return {1'b0, a[7:0]};
    endfunction

    always_comb instr_in = rom_word(pc);

    typedef struct {
        logic [15:0] pc;
        logic [8:0]  instr;
        logic [15:0] ipc;
        logic        valid;
        logic        halted;
        logic        pending;
        logic [15:0] fcnt;
        logic [15:0] scnt;
    } model_t;

    model_t m = '{pc: 16'd1, instr: 9'd0, ipc: 16'd0, valid: 1'b0, halted: 1'b0,
                  pending: 1'b0, fcnt: 16'd0, scnt: 16'd0};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One clock of fetch behaviour as described by the rules of the stage.
    function automatic model_t model_step(input model_t s, input logic rst,
                                          input logic stl, input logic rd,
                                          input logic [15:0] rd_pc);
        model_t n = s;
        logic [8:0] w;
        if (rst) begin
            n = '{pc: 16'd1, instr: 9'd0, ipc: 16'd0, valid: 1'b0, halted: 1'b0,
                  pending: 1'b0, fcnt: 16'd0, scnt: 16'd0};
            return n;
        end
        if (s.halted) return n;
        if (stl) n.scnt = sat_inc(s.scnt);
        if (rd) begin
            n.pc      = rd_pc;
            n.valid   = 1'b0;
            n.pending = 1'b0;
        end else if (stl) begin
            // everything holds
        end else if (s.pending) begin
            n.halted  = 1'b1;
            n.valid   = 1'b0;
            n.pending = 1'b0;
        end else begin
            w       = rom_word(s.pc);
            n.instr = w;
            n.ipc   = s.pc;
            n.valid = 1'b1;
            n.fcnt  = sat_inc(s.fcnt);
            if (w[8:4] == TB_HALT_OP) n.pending = 1'b1;
            else                      n.pc      = s.pc + 16'd1;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, reset, stall, redirect, redirect_pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_pc",         pc,         m.pc);
            check("mdl_ifid_instr", ifid_instr, m.instr);
            check("mdl_ifid_pc",    ifid_pc,    m.ipc);
            check("mdl_ifid_valid", ifid_valid, m.valid);
            check("mdl_halted",     halted,     m.halted);
`ifdef FETCH_PERF_CNT_EN
            check("mdl_fetch_cnt",  fetch_cnt,  m.fcnt);
            check("mdl_stall_cnt",  stall_cnt,  m.scnt);
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // {stall, redirect, redirect_pc} mixed traffic checked only by the model
    logic [17:0] mix [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mix = '{ {2'b00, 16'h0000}, {2'b10, 16'h0000}, {2'b11, 16'h0100},
                 {2'b00, 16'h0000}, {2'b00, 16'h0000}, {2'b10, 16'h0000},
                 {2'b01, 16'h0200}, {2'b00, 16'h0000}, {2'b11, 16'h0300},
                 {2'b00, 16'h0000} };
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;

        cyc();
        cmp_en = 1'b1;
        check("rst_pc", pc, 16'd1);
        check("rst_ifid_pc", ifid_pc, 16'd0);
        check("rst_ifid_instr", ifid_instr, 9'd0);
        check("rst_valid", ifid_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        reset = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("run_ifid_pc", ifid_pc, i);
            check("run_valid", ifid_valid, 1'b1);
        end
        cyc();
        check("pre_stall_ifid_pc", ifid_pc, 16'd5);
        check("pre_stall_pc", pc, 16'd6);

        stall = 1'b1;
        repeat (3) begin
            cyc();
            check("stall_ifid_pc", ifid_pc, 16'd5);
            check("stall_pc", pc, 16'd6);
        end
        stall = 1'b0;
        cyc();
        check("resume_ifid_pc", ifid_pc, 16'd6);

        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'd16;
        cyc();
        check("redir_pc", pc, 16'd16);
        check("redir_valid", ifid_valid, 1'b0);
        stall = 1'b0; redirect = 1'b0;
        cyc();
        check("redir_ifid_pc", ifid_pc, 16'd16);
        check("redir_ifid_valid", ifid_valid, 1'b1);

        // Fetch runs through 79 into the halt word at 80.
        halt_on = 1'b1; halt_addr = 16'd80;
        redirect = 1'b1; redirect_pc = 16'd77;
        cyc();
        redirect = 1'b0;
        check("halt_setup_pc", pc, 16'd77);
        repeat (3) cyc();
        check("halt_prev_ifid_pc", ifid_pc, 16'd79);
        check("halt_prev_pc", pc, 16'd80);
        cyc();
        check("halt_ifid_instr", ifid_instr, {TB_HALT_OP, 4'h0});
        check("halt_pend_pc", pc, 16'd80);
        check("halt_pend_valid", ifid_valid, 1'b1);
        check("halt_pend_halted", halted, 1'b0);
        stall = 1'b1;
        cyc();
        check("halt_pend_stall_valid", ifid_valid, 1'b1);
        check("halt_pend_stall_ifid_pc", ifid_pc, 16'd80);
        stall = 1'b0;
        cyc();
        check("halted_flag", halted, 1'b1);
        check("halted_valid", ifid_valid, 1'b0);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'd5;
        repeat (3) cyc();
        check("halted_ignore_pc", pc, 16'd80);
        check("halted_ignore_flag", halted, 1'b1);
        check("halted_ignore_valid", ifid_valid, 1'b0);

        redirect = 1'b0; stall = 1'b0; reset = 1'b1;
        cyc();
        check("rst_from_halted_pc", pc, 16'd1);
        check("rst_from_halted_flag", halted, 1'b0);
        reset = 1'b0;

        // Halt fetched, then redirected away while pending.
        halt_addr = 16'd66;
        redirect = 1'b1; redirect_pc = 16'd65;
        cyc();
        redirect = 1'b0;
        cyc();
        check("pend_redir_ifid_65", ifid_pc, 16'd65);
        cyc();
        check("pend_redir_halt_pc", pc, 16'd66);
        check("pend_redir_halt_valid", ifid_valid, 1'b1);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'd68;
        cyc();
        check("pend_redir_pc", pc, 16'd68);
        check("pend_redir_valid", ifid_valid, 1'b0);
        check("pend_redir_halted", halted, 1'b0);
        stall = 1'b0; redirect = 1'b0; halt_on = 1'b0;
        cyc();
        check("pend_redir_ifid_pc", ifid_pc, 16'd68);
        check("pend_redir_pc_next", pc, 16'd69);
        check("pend_redir_still_run", halted, 1'b0);

        redirect = 1'b1; redirect_pc = 16'hFFFF;
        cyc();
        redirect = 1'b0;
        check("wrap_load_pc", pc, 16'hFFFF);
        cyc();
        check("wrap_ifid_ffff", ifid_pc, 16'hFFFF);
        check("wrap_pc_zero", pc, 16'h0000);
        cyc();
        check("wrap_ifid_zero", ifid_pc, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            stall       = mix[i][17];
            redirect    = mix[i][16];
            redirect_pc = mix[i][15:0];
            cyc();
        end
        stall = 1'b0; redirect = 1'b0;
        repeat (2) cyc();

        stall = 1'b1; reset = 1'b1;
        cyc();
        check("rst_mid_stall_pc", pc, 16'd1);
        check("rst_mid_stall_valid", ifid_valid, 1'b0);
        stall = 1'b0; reset = 1'b0;
        repeat (2) cyc();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
